// File: rtl/audio_mixer.sv
// Sample-rate voice mixer: divides the system clock to the audio rate, snapshots
// the voices on each tick, sums enabled voices serially, scales by volume and saturates.
module audio_mixer #(
  parameter int NUM_VOICES = 3,
  parameter int VOICE_W    = 12,
  parameter int CLK_DIV    = 1000
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [NUM_VOICES*VOICE_W-1:0] voice_i,
  input  logic [NUM_VOICES-1:0]         voice_en_i,
  input  logic [3:0]                    volume_i,
  output logic [13:0]                   audio_o,
  output logic                          audio_valid_o
);

  localparam int CNT_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int IDX_W  = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam int ACC_W  = VOICE_W + 3;
  localparam int PROD_W = ACC_W + 5;
  localparam logic signed [PROD_W-1:0] SAT_MAX = PROD_W'(8191);
  localparam logic signed [PROD_W-1:0] SAT_MIN = PROD_W'(-8192);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_SCALE = 2'd2
  } state_t;

  state_t                          state_q, state_d;
  logic [CNT_W-1:0]                cnt_q, cnt_d;
  logic signed [ACC_W-1:0]         acc_q, acc_d;
  logic [IDX_W-1:0]                idx_q, idx_d;
  logic [NUM_VOICES*VOICE_W-1:0]   voice_q, voice_d;
  logic [NUM_VOICES-1:0]           en_q, en_d;
  logic [3:0]                      vol_q, vol_d;
  logic [13:0]                     audio_q, audio_d;
  logic                            valid_q, valid_d;

  logic                            tick_s;
  logic signed [VOICE_W-1:0]       voice_arr_s [NUM_VOICES];
  logic signed [ACC_W-1:0]         addend_s;
  logic signed [PROD_W-1:0]        prod_s;
  logic signed [PROD_W-1:0]        y_s;
  logic [13:0]                     sat_s;

  assign tick_s = (cnt_q == CNT_W'(CLK_DIV - 1));

  for (genvar k = 0; k < NUM_VOICES; k++) begin : g_voice
    assign voice_arr_s[k] = voice_q[k*VOICE_W +: VOICE_W];
  end

  // Sign-extended contribution of the voice currently addressed by idx.
  always_comb begin
    if (en_q[idx_q]) begin
      addend_s = {{3{voice_arr_s[idx_q][VOICE_W-1]}}, voice_arr_s[idx_q]};
    end else begin
      addend_s = '0;
    end
  end

  // Volume scaling with floor shift, then clamp to signed 14 bits.
  always_comb begin
    prod_s = acc_q * $signed({1'b0, vol_q});
    y_s    = prod_s >>> 3'd3;
    if (y_s > SAT_MAX) begin
      sat_s = 14'h1FFF;
    end else if (y_s < SAT_MIN) begin
      sat_s = 14'h2000;
    end else begin
      sat_s = y_s[13:0];
    end
  end

  // Sample-rate divider.
  always_comb begin
    if (tick_s) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Next-state and datapath control for the capture/accumulate/scale sequence.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    idx_d   = idx_q;
    voice_d = voice_q;
    en_d    = en_q;
    vol_d   = vol_q;
    audio_d = audio_q;
    valid_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (tick_s) begin
          voice_d = voice_i;
          en_d    = voice_en_i;
          vol_d   = volume_i;
          acc_d   = '0;
          idx_d   = '0;
          state_d = ST_ACCUM;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ACCUM: begin
        acc_d = acc_q + addend_s;
        if (idx_q == IDX_W'(NUM_VOICES - 1)) begin
          idx_d   = '0;
          state_d = ST_SCALE;
        end else begin
          idx_d   = idx_q + IDX_W'(1);
        end
      end
      ST_SCALE: begin
        audio_d = sat_s;
        valid_d = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      idx_q   <= '0;
      voice_q <= '0;
      en_q    <= '0;
      vol_q   <= 4'd0;
      audio_q <= 14'd0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      idx_q   <= idx_d;
      voice_q <= voice_d;
      en_q    <= en_d;
      vol_q   <= vol_d;
      audio_q <= audio_d;
      valid_q <= valid_d;
    end
  end

  assign audio_o       = audio_q;
  assign audio_valid_o = valid_q;

  audio_mixer_chk u_chk (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .tick_i (tick_s),
    .idle_i (state_q == ST_IDLE)
  );

endmodule

// Flags a sample tick arriving while a previous sample is still being mixed.
module audio_mixer_chk (
  input logic clk_i,
  input logic rst_i,
  input logic tick_i,
  input logic idle_i
);

  a_tick_in_idle: assert property (@(posedge clk_i) disable iff (rst_i) tick_i |-> idle_i);

endmodule

// File: doc/audio_mixer.md
# audio_mixer

Sample-rate mixer directly upstream of `delta_sigma`. It divides the 50 MHz system clock to the audio sample rate and snapshots the per-voice samples on each sample tick. It then sums the enabled voices serially, applies a 4-bit master volume, and saturates to signed 14 bits. Its outputs `audio_o` / `audio_valid_o` drive `audio_i` / `audio_valid_i` of `delta_sigma` directly.

## Interface
- `NUM_VOICES`, 3, number of voice inputs; range 1..8
- `VOICE_W`, 12, signed width of each voice sample
- `CLK_DIV`, 1000, clock cycles per output sample (50 MHz → 50 kHz); must be ≥ `NUM_VOICES`+4

- `clk_i`  in  1  system clock, 50 MHz; the only clock
- `rst_i`  in  1  synchronous, active-high reset
- `voice_i`  in  `NUM_VOICES*VOICE_W`  packed signed voice samples; voice k at bits [k*VOICE_W +: VOICE_W]
- `voice_en_i`  in  `NUM_VOICES`  per-voice enable; bit k gates voice k
- `volume_i`  in  4  master volume, unsigned 0..15; gain = volume/8
- `audio_o`  out  14  signed mixed sample; held between updates
- `audio_valid_o`  out  1  one-cycle strobe; `audio_o` is new in the same cycle

## Operation
- Tick counter `cnt`, 0..`CLK_DIV`-1, increments every cycle and wraps to 0. `tick` = (`cnt` == `CLK_DIV`-1).
- FSM states: IDLE, ACCUM, SCALE.
- **IDLE**
  - On `tick`: capture `voice_i`, `voice_en_i` and `volume_i` into shadow registers.
  - Same cycle: clear `acc`, set `idx`=0, go to ACCUM.
  - Inputs are don't-care outside the tick cycle.
- **ACCUM**
  - One voice per cycle: `acc` += en[idx] ? sign-extended voice[idx] : 0.
  - `idx` increments each cycle; after `idx`=`NUM_VOICES`-1, go to SCALE.
  - `acc` width is `VOICE_W`+3, so it cannot overflow.
- **SCALE**
  - `prod` = `acc` * volume, with volume zero-extended and signed arithmetic.
  - `y` = `prod` >>> 3 (arithmetic shift; floors toward −∞).
  - `audio_o` <= `y` clamped to [−8192, 8191].
  - `audio_valid_o` <= 1, then go to IDLE.
- `audio_valid_o` is registered. It is high for exactly one cycle per sample and 0 otherwise.
- A tick in a non-IDLE state cannot occur, because `CLK_DIV` ≥ `NUM_VOICES`+4. The implementation adds an assertion that flags it.
- **Reset values** (`rst_i` high at a clock edge):
  - `cnt`=0, state=IDLE, `acc`=0, `idx`=0.
  - `audio_o`=0, `audio_valid_o`=0.
  - Shadow registers = 0.
- **Reset mid-operation:** any sample in progress is aborted with no valid pulse. Timing after release is identical to cold reset.

## Timing
- Cycle 0 is the first cycle with `rst_i` low; `cnt`=0 in cycle 0.
- First `tick` is in cycle `CLK_DIV`-1. Later ticks are every `CLK_DIV` cycles.
- Latency from the tick cycle T:
  - ACCUM in cycles T+1..T+`NUM_VOICES`.
  - SCALE in cycle T+`NUM_VOICES`+1.
  - `audio_valid_o`=1 with the new `audio_o` in cycle T+`NUM_VOICES`+2.
- Defaults: first valid in cycle 1004, then 2004, 3004, and so on.
- Input sampling is only in the tick cycle. Changes to any input in other cycles do not affect the current sample.
- `audio_o` is stable from its valid cycle until the next valid cycle.

## Test plan
1. **Reset and cadence:** hold `rst_i` for 5 cycles, then release (defaults) → `audio_o`=0 and `audio_valid_o`=0 through cycle 1003. Valid pulses occur exactly in cycles 1004, 2004 and 3004, each one cycle wide.
2. **Basic mix:** voices {100, 200, 300}, en=3'b111, volume=8 → `audio_o`=600. With volume=4 → 300. With volume=0 → 0.
3. **Saturation:**
   - All voices 2047, volume 15 → 6141*15>>>3 = 11514, clamped to 8191.
   - All voices −2048, volume 15 → −11520, clamped to −8192.
4. **Enable mask and rounding:**
   - Voices {100, −500, 300}, en=3'b010, volume 8 → −500.
   - Voice0 = −1 only enabled, volume 1 → −1 (floor).
   - Voice0 = 7 only enabled, volume 1 → 0.
5. **Sampling window:** set voices {10, 20, 30}, volume 8 at the tick cycle. Change them to {1000, 1000, 1000} in cycle T+1 → valid in T+5 carries 60. The next sample carries 3000.
6. **Reset mid-ACCUM:** assert `rst_i` for 1 cycle at T+2 → no valid pulse for that sample and `audio_o`=0. The next valid arrives 1005 cycles after the reset cycle, i.e. cycle 1004 counted from release.
